// File: rtl/vad_gate.sv
// vad_gate: energy-based voice activity detector gating PCM samples into the audio buffer
// clk, rst (async, active high); sample_in/sample_valid: PCM stream; buffer_full: downstream full flag
// data_out/write_en: gated buffer write port; speech_active: gate open after the last frame decision
// frame_energy/energy_valid: mean |x| of the last frame; drop_count: saturating count of samples lost to buffer_full
module vad_gate #(
  parameter int          FRAME_LEN    = 256,
  parameter int          LOG2_FRAME   = $clog2(FRAME_LEN),
  parameter logic [15:0] TH_ON        = 16'd1000,
  parameter logic [15:0] TH_OFF       = 16'd500,
  parameter int          ONSET_FRAMES = 2,
  parameter int          HANG_FRAMES  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic        buffer_full,
  output logic [15:0] data_out,
  output logic        write_en,
  output logic        speech_active,
  output logic [15:0] frame_energy,
  output logic        energy_valid,
  output logic [15:0] drop_count
);
  localparam int AW = 16 + LOG2_FRAME + 1;
  typedef enum logic [1:0] {SILENCE, ONSET, SPEECH, HANGOVER} state_t;
  state_t state_q, state_d;
  logic [LOG2_FRAME-1:0] cnt_q;
  logic [AW-1:0] acc_q, total, mean_w;
  logic [3:0] onset_q, onset_d, onset_n;
  logic [7:0] hang_q, hang_d, hang_n;
  logic [16:0] abs_v;
  logic [15:0] mean;
  logic frame_end, gate, hi, lo, onset_done, hang_done;
  // negate in 17 bits so -32768 maps to +32768
  assign abs_v = sample_in[15] ? 17'd0 - {1'b1, sample_in} : {1'b0, sample_in};
  assign total = acc_q + AW'(abs_v);
  assign mean_w = total >> LOG2_FRAME;
  assign mean = |mean_w[AW-1:16] ? 16'hFFFF : mean_w[15:0];
  assign frame_end = sample_valid && (&cnt_q);
  assign gate = state_q == SPEECH || state_q == HANGOVER;
  assign hi = mean >= TH_ON;
  assign lo = mean < TH_OFF;
  assign onset_n = onset_q + 4'd1;
  assign hang_n = hang_q + 8'd1;
  assign onset_done = onset_n == 4'(ONSET_FRAMES);
  assign hang_done = hang_n == 8'(HANG_FRAMES);
  always_comb begin
    state_d = state_q;
    onset_d = onset_q;
    hang_d = hang_q;
    if (frame_end)
      case (state_q)
        SILENCE: if (hi) begin
          state_d = ONSET_FRAMES == 1 ? SPEECH : ONSET;
          onset_d = ONSET_FRAMES == 1 ? 4'd0 : 4'd1;
        end
        ONSET: begin
          state_d = !hi ? SILENCE : onset_done ? SPEECH : ONSET;
          onset_d = hi && !onset_done ? onset_n : 4'd0;
        end
        SPEECH: if (lo) begin
          state_d = HANGOVER;
          hang_d = 8'd0;
        end
        HANGOVER: begin
          state_d = hi ? SPEECH : hang_done ? SILENCE : HANGOVER;
          hang_d = hi || hang_done ? 8'd0 : hang_n;
        end
        default: state_d = SILENCE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SILENCE;
      cnt_q <= '0;
      acc_q <= '0;
      onset_q <= '0;
      hang_q <= '0;
      data_out <= '0;
      write_en <= 1'b0;
      speech_active <= 1'b0;
      frame_energy <= '0;
      energy_valid <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      onset_q <= onset_d;
      hang_q <= hang_d;
      energy_valid <= frame_end;
      write_en <= sample_valid && gate && !buffer_full;
      speech_active <= state_d == SPEECH || state_d == HANGOVER;
      if (sample_valid) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= frame_end ? '0 : total;
        data_out <= sample_in;
        if (gate && buffer_full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (frame_end) frame_energy <= mean;
    end
endmodule

// File: tb/tb_vad_gate.sv
// tb_vad_gate: table-driven check of vad_gate with 4-sample frames
module tb_vad_gate;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        buffer_full = 1'b0;
  logic [15:0] data_out, frame_energy, drop_count;
  logic        write_en, speech_active, energy_valid;
  typedef struct {
    logic        rb;
    logic        v;
    logic [15:0] s;
    logic        full;
    logic        we;
    logic [15:0] d;
    logic        sa;
    logic        ev;
    logic [15:0] fe;
    logic [15:0] dc;
  } vec_t;
  vec_t tbl[$];
  logic [15:0] last_d = '0;
  int tests = 0;
  int failed = 0;
  vad_gate #(
    .FRAME_LEN(4), .TH_ON(16'd1000), .TH_OFF(16'd500), .ONSET_FRAMES(2), .HANG_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .buffer_full(buffer_full), .data_out(data_out), .write_en(write_en),
    .speech_active(speech_active), .frame_energy(frame_energy),
    .energy_valid(energy_valid), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  function automatic void push(input int rb, v, s, full, we, sa, ev, fe, dc);
    vec_t t;
    if (rb != 0) last_d = '0;
    if (v != 0) last_d = 16'(s);
    t.rb = 1'(rb);
    t.v = 1'(v);
    t.s = 16'(s);
    t.full = 1'(full);
    t.we = 1'(we);
    t.d = last_d;
    t.sa = 1'(sa);
    t.ev = 1'(ev);
    t.fe = 16'(fe);
    t.dc = 16'(dc);
    tbl.push_back(t);
  endfunction
  // one frame of +a,-a,+a,-a; speech_active is sa0 until the frame-end sample, which gives sa1 and energy fe1
  function automatic void frm(input int rb, a, we, sa0, sa1, fe0, fe1, dc);
    push(rb, 1, a, 0, we, sa0, 0, fe0, dc);
    push(0, 1, -a, 0, we, sa0, 0, fe0, dc);
    push(0, 1, a, 0, we, sa0, 0, fe0, dc);
    push(0, 1, -a, 0, we, sa1, 1, fe1, dc);
  endfunction
  task automatic run(input int i, input vec_t t);
    @(negedge clk);
    if (t.rb) begin
      rst = 1'b1;
      #1;
      tests++;
      if ({data_out, write_en, speech_active, frame_energy, energy_valid, drop_count} !== 51'd0) begin
        failed++;
        $display("FAIL vec %0d async_reset: got d=%h we=%b sa=%b fe=%h ev=%b dc=%h, want all 0",
                 i, data_out, write_en, speech_active, frame_energy, energy_valid, drop_count);
      end
      #1 rst = 1'b0;
    end
    sample_valid = t.v;
    sample_in = t.s;
    buffer_full = t.full;
    @(posedge clk);
    #1;
    tests++;
    if (data_out !== t.d || write_en !== t.we || speech_active !== t.sa || energy_valid !== t.ev ||
        frame_energy !== t.fe || drop_count !== t.dc) begin
      failed++;
      $display("FAIL vec %0d outputs: got d=%h we=%b sa=%b ev=%b fe=%0d dc=%0d, want d=%h we=%b sa=%b ev=%b fe=%0d dc=%0d",
               i, data_out, write_en, speech_active, energy_valid, frame_energy, drop_count,
               t.d, t.we, t.sa, t.ev, t.fe, t.dc);
    end
  endtask
  initial begin
    frm(1, 100, 0, 0, 0, 0, 100, 0);
    frm(0, 100, 0, 0, 0, 100, 100, 0);
    frm(0, 100, 0, 0, 0, 100, 100, 0);
    frm(0, 2000, 0, 0, 0, 100, 2000, 0);
    frm(0, 100, 0, 0, 0, 2000, 100, 0);
    frm(0, 2000, 0, 0, 0, 100, 2000, 0);
    frm(0, 2000, 0, 0, 1, 2000, 2000, 0);
    frm(0, 1234, 1, 1, 1, 2000, 1234, 0);
    frm(0, 300, 1, 1, 1, 1234, 300, 0);
    frm(0, 300, 1, 1, 1, 300, 300, 0);
    frm(0, 300, 1, 1, 0, 300, 300, 0);
    frm(0, 300, 0, 0, 0, 300, 300, 0);
    frm(0, 2000, 0, 0, 0, 300, 2000, 0);
    frm(0, 2000, 0, 0, 1, 2000, 2000, 0);
    frm(0, 300, 1, 1, 1, 2000, 300, 0);
    frm(0, 1200, 1, 1, 1, 300, 1200, 0);
    frm(0, 300, 1, 1, 1, 1200, 300, 0);
    frm(0, 300, 1, 1, 1, 300, 300, 0);
    for (int k = 0; k < 3; k++) push(0, 1, -32768, 0, 1, 1, 0, 300, 0);
    push(0, 1, -32768, 0, 1, 1, 1, 32768, 0);
    frm(0, 1, 1, 1, 1, 32768, 1, 0);
    frm(0, 1200, 1, 1, 1, 1, 1200, 0);
    push(0, 1, 1200, 1, 0, 1, 0, 1200, 1);
    push(0, 1, -1200, 1, 0, 1, 0, 1200, 2);
    push(0, 1, 1200, 1, 0, 1, 0, 1200, 3);
    push(0, 1, -1200, 1, 0, 1, 1, 1200, 4);
    push(0, 1, 1200, 1, 0, 1, 0, 1200, 5);
    push(0, 1, -1200, 0, 1, 1, 0, 1200, 5);
    push(0, 1, 1200, 0, 1, 1, 0, 1200, 5);
    push(0, 1, -1200, 0, 1, 1, 1, 1200, 5);
    push(0, 1, 1200, 0, 1, 1, 0, 1200, 5);
    push(0, 1, -1200, 0, 1, 1, 0, 1200, 5);
    for (int k = 0; k < 10; k++) push(0, 0, 16'h5A5A, 0, 0, 1, 0, 1200, 5);
    push(0, 1, 1200, 0, 1, 1, 0, 1200, 5);
    push(0, 1, -1200, 0, 1, 1, 1, 1200, 5);
    push(0, 1, 1200, 0, 1, 1, 0, 1200, 5);
    push(0, 1, -1200, 0, 1, 1, 0, 1200, 5);
    frm(1, 100, 0, 0, 0, 0, 100, 0);
    frm(0, 100, 0, 0, 0, 100, 100, 0);
    frm(0, 100, 0, 0, 0, 100, 100, 0);
    foreach (tbl[i]) run(i, tbl[i]);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
